// File: rtl/dot_product_accumulator_if.sv
// Stream bundle for dot_product_accumulator: element-pair input channel and
// dot-product result channel, each with a valid/ready handshake.
interface dot_product_accumulator_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 18
);
    logic                  inValid;
    logic                  inReady;
    logic [DATA_WIDTH-1:0] inData_A;
    logic [DATA_WIDTH-1:0] inData_B;
    logic                  outValid;
    logic                  outReady;
    logic [ACC_WIDTH-1:0]  outData_C;
    logic                  outBusy;

    modport master (
        output inValid, inData_A, inData_B, outReady,
        input  inReady, outValid, outData_C, outBusy
    );

    modport slave (
        input  inValid, inData_A, inData_B, outReady,
        output inReady, outValid, outData_C, outBusy
    );
endinterface

// File: rtl/dot_product_accumulator.sv
// Two-stage dot-product engine: Vedic 8x8 product register, then accumulate/output.
// Define DOTACC_SIGNED_EN for two's-complement operands and result (default unsigned).
module dot_product_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 4,
    parameter int ACC_WIDTH  = 18
) (
    input logic                      clk,
    input logic                      rst,
    dot_product_accumulator_if.slave bus
);

`ifdef DOTACC_SIGNED_EN
    localparam int PROD_WIDTH = 2*DATA_WIDTH + 1;
`else
    localparam int PROD_WIDTH = 2*DATA_WIDTH;
`endif
    localparam int                   CNT_WIDTH = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(VEC_LEN - 1);

    function automatic logic [3:0] vedic2(input logic [1:0] a, input logic [1:0] b);
        logic       c;
        logic [3:0] p;
        p[0] = a[0] & b[0];
        p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
        c    = (a[1] & b[0]) & (a[0] & b[1]);
        p[2] = (a[1] & b[1]) ^ c;
        p[3] = (a[1] & b[1]) & c;
        return p;
    endfunction

    function automatic logic [7:0] vedic4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] q0, q1, q2, q3;
        q0 = vedic2(a[1:0], b[1:0]);
        q1 = vedic2(a[3:2], b[1:0]);
        q2 = vedic2(a[1:0], b[3:2]);
        q3 = vedic2(a[3:2], b[3:2]);
        return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    endfunction

    function automatic logic [15:0] vedic8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q0, q1, q2, q3;
        q0 = vedic4(a[3:0], b[3:0]);
        q1 = vedic4(a[7:4], b[3:0]);
        q2 = vedic4(a[3:0], b[7:4]);
        q3 = vedic4(a[7:4], b[7:4]);
        return {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
    endfunction

    logic                  stall;
    logic                  accept;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [PROD_WIDTH-1:0] prod_comb;
    logic                  p_valid;
    logic                  p_first;
    logic                  p_last;
    logic [PROD_WIDTH-1:0] p_prod;
    logic [ACC_WIDTH-1:0]  prod_ext;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic                  out_valid;
    logic [ACC_WIDTH-1:0]  out_data;

    // The whole pipeline freezes while a result waits, so no bubble is ever squeezed out.
    assign stall         = out_valid && !bus.outReady;
    assign bus.inReady   = !stall;
    assign accept        = bus.inValid && !stall;
    assign bus.outValid  = out_valid;
    assign bus.outData_C = out_data;
    assign bus.outBusy   = (cnt != '0) || p_valid;

`ifdef DOTACC_SIGNED_EN
    // Magnitudes go through the unsigned multiplier; -128 becomes 128, which still fits.
    logic [7:0]  mag_a, mag_b;
    logic [15:0] mag_p;
    logic        neg;

    always_comb begin
        mag_a     = bus.inData_A[7] ? (~bus.inData_A + 8'd1) : bus.inData_A;
        mag_b     = bus.inData_B[7] ? (~bus.inData_B + 8'd1) : bus.inData_B;
        neg       = bus.inData_A[7] ^ bus.inData_B[7];
        mag_p     = vedic8(mag_a, mag_b);
        prod_comb = neg ? (~{1'b0, mag_p} + PROD_WIDTH'(1)) : {1'b0, mag_p};
    end

    assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){p_prod[PROD_WIDTH-1]}}, p_prod};
`else
    assign prod_comb = vedic8(bus.inData_A, bus.inData_B);
    assign prod_ext  = {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, p_prod};
`endif

    // NOTE: combinational blocks assign every output first so no latch is inferred.
    always_comb begin
        acc_next = acc + prod_ext;
        if (p_first) acc_next = prod_ext;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            p_valid <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
            p_prod  <= '0;
        end else if (!stall) begin
            p_valid <= accept;
            if (accept) begin
                cnt     <= (cnt == CNT_LAST) ? '0 : cnt + CNT_WIDTH'(1);
                p_first <= (cnt == '0);
                p_last  <= (cnt == CNT_LAST);
                p_prod  <= prod_comb;
            end
        end
    end

    // A first-tagged product overwrites acc, so back-to-back vectors need no clear cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!stall) begin
            if (out_valid) out_valid <= 1'b0;
            if (p_valid) begin
                acc <= acc_next;
                if (p_last) begin
                    out_valid <= 1'b1;
                    out_data  <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench for dot_product_accumulator: directed vectors with literal
// expectations plus randomized traffic against a queue-based dot-product model.
module tb_dot_product_accumulator;
    localparam int DW = 8;
    localparam int VL = 4;
    localparam int AW = 18;

    typedef struct {
        logic [AW-1:0] val;
        int            avail;
        int            acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dot_product_accumulator_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

    dot_product_accumulator #(.DATA_WIDTH(DW), .VEC_LEN(VL), .ACC_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            valid_cycles = 0;
    int            inready_low = 0;
    exp_t          expq[$];
    logic [DW-1:0] part_a[$];
    logic [DW-1:0] part_b[$];
    logic [AW-1:0] res_val[$];
    int            res_cyc[$];
    int            res_lat[$];
    logic          prev_hold = 1'b0;
    logic [AW-1:0] prev_data = '0;
    bit            rand_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference dot product straight from the arithmetic definition, wrapped to AW bits.
    function automatic logic [AW-1:0] dot(input logic [DW-1:0] a[$], input logic [DW-1:0] b[$]);
        longint s = 0;
        for (int i = 0; i < a.size(); i++) begin
`ifdef DOTACC_SIGNED_EN
            s += longint'($signed(a[i])) * longint'($signed(b[i]));
`else
            s += longint'(a[i]) * longint'(b[i]);
`endif
        end
        return AW'(s);
    endfunction

    // Compare process: sampled on the falling edge, values seen here take effect on the next rise.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            part_a.delete();
            part_b.delete();
            expq.delete();
            prev_hold = 1'b0;
        end else begin
            check("in_ready_rule", bus.inReady, !(bus.outValid && !bus.outReady));
            if (!bus.inReady) inready_low++;
            if (bus.outValid) valid_cycles++;
            if (prev_hold) begin
                check("hold_valid", bus.outValid, 1'b1);
                check("hold_data", bus.outData_C, prev_data);
            end
            if (expq.size() == 0) begin
                check("valid_without_result", bus.outValid, 1'b0);
            end else if (bus.outValid) begin
                check("result_value", bus.outData_C, expq[0].val);
                check("result_not_early", cyc >= expq[0].avail, 1'b1);
                if (bus.outReady) begin
                    res_val.push_back(bus.outData_C);
                    res_cyc.push_back(cyc);
                    res_lat.push_back(cyc - expq[0].acc_cyc);
                    void'(expq.pop_front());
                end
            end else if (cyc >= expq[0].avail) begin
                check("result_late", bus.outValid, 1'b1);
            end
            if (bus.inValid && bus.inReady) begin
                part_a.push_back(bus.inData_A);
                part_b.push_back(bus.inData_B);
                if (part_a.size() == VL) begin
                    expq.push_back('{val: dot(part_a, part_b), avail: cyc + 2, acc_cyc: cyc});
                    part_a.delete();
                    part_b.delete();
                end
            end
            prev_hold = bus.outValid && !bus.outReady;
            prev_data = bus.outData_C;
        end
    end

    task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int waited = 0;
        bit done = 1'b0;
        bus.inValid  = 1'b1;
        bus.inData_A = a;
        bus.inData_B = b;
        while (!done) begin
            @(negedge clk);
            done = bus.inReady;
            @(posedge clk);
            #1;
            waited++;
            if (!done && waited > 200) begin
                check("beat_accept_timeout", waited, 0);
                done = 1'b1;
            end
        end
    endtask

    task automatic send_vec(input logic [DW-1:0] a[VL], input logic [DW-1:0] b[VL]);
        for (int i = 0; i < VL; i++) send_beat(a[i], b[i]);
    endtask

    task automatic idle(input int n);
        bus.inValid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        res_val.delete();
        res_cyc.delete();
        res_lat.delete();
    endtask

    task automatic wait_results(input int n);
        int w = 0;
        while (res_val.size() < n && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("result_count", res_val.size(), n);
    endtask

    logic [DW-1:0] va[VL], vb[VL], vc[VL], vd[VL];
    int            vc0;

    initial begin
        bus.inValid  = 1'b0;
        bus.inData_A = '0;
        bus.inData_B = '0;
        bus.outReady = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", bus.outValid, 1'b0);
        check("reset_out_data", bus.outData_C, 0);
        check("reset_out_busy", bus.outBusy, 1'b0);
        check("reset_in_ready", bus.inReady, 1'b1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic dot product: 1*5+2*6+3*7+4*8 = 70, two edges after the last accept
        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        vb = '{8'd5, 8'd6, 8'd7, 8'd8};
        clear_log();
        vc0 = valid_cycles;
        send_vec(va, vb);
        idle(1);
        wait_results(1);
        idle(3);
        if (res_val.size() >= 1) begin
            check("basic_value", res_val[0], 70);
            check("basic_latency", res_lat[0], 2);
        end
        check("basic_valid_pulse", valid_cycles - vc0, 1);
        check("idle_busy", bus.outBusy, 1'b0);

`ifdef DOTACC_SIGNED_EN
        // Signed operands: -5 + 16384 - 127 - 6 = 16246, then -128*127 = -16256
        va = '{8'hFF, 8'h80, 8'h7F, 8'h02};
        vb = '{8'h05, 8'h80, 8'hFF, 8'hFD};
        vc = '{8'h80, 8'h80, 8'h80, 8'h80};
        vd = '{8'h7F, 8'h00, 8'h00, 8'h00};
        clear_log();
        send_vec(va, vb);
        send_vec(vc, vd);
        idle(1);
        wait_results(2);
        if (res_val.size() >= 2) begin
            check("signed_mixed", res_val[0], 16246);
            check("signed_min", res_val[1], AW'(-16256));
        end
`else
        // Maximum unsigned operands: 4*65025 = 260100 fits 18 bits
        va = '{8'd255, 8'd255, 8'd255, 8'd255};
        clear_log();
        send_vec(va, va);
        idle(1);
        wait_results(1);
        if (res_val.size() >= 1) check("max_value", res_val[0], 260100);
`endif

        // Back-to-back vectors: 4 then 24, exactly 4 cycles apart, no input stall
        va = '{8'd1, 8'd1, 8'd1, 8'd1};
        vc = '{8'd2, 8'd2, 8'd2, 8'd2};
        vd = '{8'd3, 8'd3, 8'd3, 8'd3};
        clear_log();
        inready_low = 0;
        send_vec(va, va);
        send_vec(vc, vd);
        idle(1);
        wait_results(2);
        if (res_val.size() >= 2) begin
            check("b2b_first", res_val[0], 4);
            check("b2b_second", res_val[1], 24);
            check("b2b_spacing", res_cyc[1] - res_cyc[0], 4);
        end
        check("b2b_in_ready_low", inready_low, 0);

        // Backpressure: first result held for 5 cycles while input keeps arriving
        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        vb = '{8'd5, 8'd6, 8'd7, 8'd8};
        clear_log();
        bus.outReady = 1'b0;
        fork
            begin
                send_vec(va, vb);
                send_vec(vc, vd);
                idle(1);
            end
            begin
                int w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!bus.outValid && w < 100);
                check("bp_valid_seen", bus.outValid, 1'b1);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_hold_70", bus.outData_C, 70);
                    check("bp_in_ready", bus.inReady, 1'b0);
                end
                @(posedge clk);
                #1;
                bus.outReady = 1'b1;
            end
        join
        wait_results(2);
        if (res_val.size() >= 2) begin
            check("bp_first", res_val[0], 70);
            check("bp_second", res_val[1], 24);
        end

        // Asynchronous reset mid-vector discards the partial sum
        clear_log();
        send_beat(8'd9, 8'd9);
        send_beat(8'd9, 8'd9);
        bus.inValid = 1'b0;
        check("partial_busy", bus.outBusy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.outValid, 1'b0);
        check("midrst_out_busy", bus.outBusy, 1'b0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        send_vec(va, vb);
        idle(1);
        wait_results(1);
        if (res_val.size() >= 1) check("post_reset_value", res_val[0], 70);

        // Randomized traffic with random gaps and random output backpressure
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [DW-1:0] a, b;
                    if ($urandom_range(0, 3) == 0) idle(1);
                    a = ($urandom_range(0, 7) == 0) ? 8'd255 : DW'($urandom_range(0, 255));
                    b = ($urandom_range(0, 7) == 0) ? 8'd128 : DW'($urandom_range(0, 255));
                    send_beat(a, b);
                end
                idle(1);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    bus.outReady = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                bus.outReady = 1'b1;
            end
        join
        begin
            int w = 0;
            while (expq.size() != 0 && w < 200) begin
                @(posedge clk);
                #1;
                w++;
            end
        end
        idle(2);
        check("drain_empty", expq.size(), 0);
        check("final_busy", bus.outBusy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
